// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic ops, iterative shift-add mul and restoring div
// ALU_MC_DIV0_FAST_EN: when defined, divide-by-zero completes on the accept edge instead of iterating.
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] REM,
  output logic             ZERO,
  output logic             COUT,
  output logic             OVF,
  output logic             DIV0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div;
  logic             div0_fast, multi, accept, last;

  always_comb begin
`ifdef ALU_MC_DIV0_FAST_EN
    div0_fast = (ALUop == OP_DIV) && (B == '0);
`else
    div0_fast = 1'b0;
`endif
    multi = (ALUop == OP_MUL) || ((ALUop == OP_DIV) && !div0_fast);
  end

  assign accept = in_valid && in_ready;
  assign last   = (state == BUSY) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = multi ? BUSY : DONE;
      BUSY:    if (cnt == CW'(1)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Single-cycle results; the div entry only matters for the fast divide-by-zero path.
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] s_y, s_rem;
  logic             s_cout, s_ovf, s_div0;

  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    s_y    = '0;
    s_rem  = '0;
    s_cout = 1'b0;
    s_ovf  = 1'b0;
    s_div0 = 1'b0;
    case (ALUop)
      OP_ADD: begin
        s_y    = add_w[WIDTH-1:0];
        s_cout = add_w[WIDTH];
        s_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_y    = sub_w[WIDTH-1:0];
        s_cout = ~sub_w[WIDTH];
        s_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: s_y = A & B;
      OP_OR:  s_y = A | B;
      OP_XOR: s_y = A ^ B;
      OP_DIV: begin
        s_y    = '1;
        s_rem  = A;
        s_div0 = 1'b1;
      end
      default: ;
    endcase
  end

  // acc_hi/acc_lo hold {product high, multiplier} for mul and {remainder, quotient} for div.
  logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, opnd};
  assign div_ge  = ~rem_sub[WIDTH];

  always_comb begin
    if (is_div) begin
      hi_n = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (accept && multi) begin
      cnt    <= CW'(WIDTH);
      is_div <= (ALUop == OP_DIV);
      acc_hi <= '0;
      acc_lo <= (ALUop == OP_DIV) ? A : B;
      opnd   <= (ALUop == OP_DIV) ? B : A;
    end else if (state == BUSY) begin
      cnt    <= cnt - CW'(1);
      acc_hi <= hi_n;
      acc_lo <= lo_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y    <= '0;
      Y_hi <= '0;
      REM  <= '0;
      ZERO <= 1'b1;
      COUT <= 1'b0;
      OVF  <= 1'b0;
      DIV0 <= 1'b0;
    end else if (accept && !multi) begin
      Y    <= s_y;
      Y_hi <= '0;
      REM  <= s_rem;
      ZERO <= (s_y == '0);
      COUT <= s_cout;
      OVF  <= s_ovf;
      DIV0 <= s_div0;
    end else if (last) begin
      Y    <= lo_n;
      ZERO <= (lo_n == '0);
      COUT <= 1'b0;
      OVF  <= 1'b0;
      if (is_div) begin
        Y_hi <= '0;
        REM  <= hi_n;
        DIV0 <= (opnd == '0);
      end else begin
        Y_hi <= hi_n;
        REM  <= '0;
        DIV0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc (WIDTH=64 main instance, WIDTH=8 side instance)
module tb_alu_mc;
  localparam int W = 64;
`ifdef ALU_MC_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Y, Y_hi, REM;
  logic [2:0]   ALUop;
  logic         ZERO, COUT, OVF, DIV0;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] A8, B8, Y8, Yhi8, REM8;
  logic [2:0] op8;
  logic       ZERO8, COUT8, OVF8, DIV08;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Y_hi(Y_hi), .REM(REM), .ZERO(ZERO), .COUT(COUT), .OVF(OVF), .DIV0(DIV0)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .ALUop(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Y(Y8), .Y_hi(Yhi8), .REM(REM8), .ZERO(ZERO8), .COUT(COUT8), .OVF(OVF8), .DIV0(DIV08)
  );

  typedef struct {
    logic [W-1:0] y, hi, rem;
    logic         zero, cout, ovf, div0;
    int           due;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   rdy_mode = 0;
  int   ncmp = 0, nfail = 0, cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    logic [2*W-1:0] p;
    logic [W:0]     s;
    e.y = '0; e.hi = '0; e.rem = '0; e.cout = 1'b0; e.ovf = 1'b0; e.div0 = 1'b0; e.due = 0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.y = s[W-1:0]; e.cout = s[W];
        s = {a[W-1], a} + {b[W-1], b};
        e.ovf = s[W] ^ s[W-1];
      end
      3'd1: begin
        e.y = a - b; e.cout = (a >= b);
        s = {a[W-1], a} - {b[W-1], b};
        e.ovf = s[W] ^ s[W-1];
      end
      3'd2: e.y = a & b;
      3'd3: e.y = a | b;
      3'd4: e.y = a ^ b;
      3'd5: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.y = p[W-1:0]; e.hi = p[2*W-1:W];
      end
      3'd6: begin
        if (b == '0) begin e.y = '1; e.rem = a; e.div0 = 1'b1; end
        else begin e.y = a / b; e.rem = a % b; end
      end
      default: e.y = '0;
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  // Consumer side: random readiness unless a directed test pins it.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #3;
      case (rdy_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!have_cur) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1'b1, 1'b0);
        else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("latency", cyc, cur.due);
        end
      end
      if (have_cur) begin
        chk("Y", Y, cur.y);
        chk("Y_hi", Y_hi, cur.hi);
        chk("REM", REM, cur.rem);
        chk("ZERO", ZERO, cur.zero);
        chk("COUT", COUT, cur.cout);
        chk("OVF", OVF, cur.ovf);
        chk("DIV0", DIV0, cur.div0);
        chk("in_ready_low_in_done", in_ready, 1'b0);
      end
      if (out_ready) have_cur = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("idle_timeout", in_ready, 1'b1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   d;
    wait_idle();
    e = model(op, a, b);
    d = (op == 3'd5 || (op == 3'd6 && !(b == '0 && FAST))) ? W : 0;
    e.due = cyc + 1 + d;
    q.push_back(e);
    in_valid = 1'b1; A = a; B = b; ALUop = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; ALUop = 3'($urandom_range(0, 7));
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input logic [7:0] ehi, input logic [7:0] erem);
    int c0, n;
    in_valid8 = 1'b1; A8 = a; B8 = b; op8 = op; c0 = cyc;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("w8_latency", cyc, c0 + 1 + 8);
    chk("w8_Y", Y8, ey);
    chk("w8_Y_hi", Yhi8, ehi);
    chk("w8_REM", REM8, erem);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8_back_to_idle", in_ready8, 1'b1);
  endtask

  initial begin
    int n;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUop = '0;
    in_valid8 = 1'b0; A8 = '0; B8 = '0; op8 = '0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_Y", Y, 0);
    chk("rst_Y_hi", Y_hi, 0);
    chk("rst_REM", REM, 0);
    chk("rst_ZERO", ZERO, 1'b1);
    chk("rst_flags", {COUT, OVF, DIV0}, 3'b000);

    run8(3'd5, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h00);
    run8(3'd6, 8'd200, 8'd9, 8'd22, 8'h00, 8'd2);

    issue(3'd0, '1, 64'd1);
    issue(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    issue(3'd5, '1, 64'd2);
    issue(3'd6, 64'd100, 64'd7);
    issue(3'd6, 64'd5, 64'd0);
    issue(3'd7, 64'd9, 64'd9);

    // Backpressure: result must hold for 10 cycles, then drain in one cycle.
    wait_idle();
    rdy_mode = 1;
    issue(3'd1, 64'd3, 64'd5);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    repeat (10) @(posedge clk);
    #1;
    chk("bp_Y_held", Y, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("bp_COUT_held", COUT, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    rdy_mode = 2;
    @(posedge clk); #1;
    chk("bp_release_idle", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    rdy_mode = 0;

    // Reset in the middle of a multiply must discard it.
    issue(3'd5, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1 chk("abort_out_valid_in_reset", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    issue(3'd0, 64'd2, 64'd3);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 20));
      if (op == 3'd6 && $urandom_range(0, 4) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = a;
      issue(op, a, b);
    end

    n = 0;
    while ((q.size() != 0 || have_cur) && n < 1000) begin @(posedge clk); #1; n++; end
    chk("drain_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; legal range 8..128.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block idle, request accepted when in_valid&&in_ready.
REQ-006 SHALL have port A  input  WIDTH  operand A, sampled on accept.
REQ-007 SHALL have port B  input  WIDTH  operand B, sampled on accept.
REQ-008 SHALL have port ALUop  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 reserved; sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result registers valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result when out_valid&&out_ready.
REQ-011 SHALL have ports Y, Y_hi, REM  output  WIDTH each  result low, product high half, remainder.
REQ-012 SHALL have ports ZERO, COUT, OVF, DIV0  output  1 each  Y==0, carry/no-borrow, signed overflow, divide-by-zero.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL, on accept of ops 000-100 or 111, register result and enter DONE on the accept edge (latency 1 cycle).
REQ-015 SHALL, on accept of 101/110, latch A, B, op, load iteration counter with WIDTH, enter BUSY.
REQ-016 SHALL in BUSY perform one iteration per clock (mul: unsigned shift-add; div: unsigned restoring), decrement counter, enter DONE on the edge the counter reaches 0 (latency WIDTH cycles).
REQ-017 SHALL compute add: Y=A+B mod 2^WIDTH, COUT=carry out, OVF=(A[msb]==B[msb])&&(Y[msb]!=A[msb]).
REQ-018 SHALL compute sub: Y=A-B, COUT=1 when A>=B unsigned, OVF=(A[msb]!=B[msb])&&(Y[msb]!=A[msb]).
REQ-019 SHALL compute mul: {Y_hi,Y}=A*B full 2*WIDTH-bit unsigned product.
REQ-020 SHALL compute div: Y=A/B, REM=A%B unsigned; B==0 gives Y=all-ones, REM=A, DIV0=1.
REQ-021 SHALL drive Y_hi, REM, COUT, OVF, DIV0 to 0 for ops not defining them; op 111 gives Y=0, ZERO=1.
REQ-022 SHALL register ZERO as (Y==0) of the same result, valid with out_valid.
REQ-023 SHALL hold all result outputs stable while out_valid&&!out_ready.
REQ-024 SHALL return DONE->IDLE on out_valid&&out_ready; new request not accepted in that same cycle (max one op per latency+1 cycles).
REQ-025 SHALL ignore in_valid, A, B, ALUop changes while in BUSY or DONE.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force IDLE, counter 0, in_ready=1 after release, out_valid=0, Y, Y_hi, REM=0, ZERO=1, COUT=OVF=DIV0=0.
REQ-027 SHALL abort any BUSY mul/div on reset with no result presented after release.

Configuration
REQ-028 SHALL honour macro ALU_MC_DIV0_FAST_EN: defined, div with B==0 skips BUSY and enters DONE on the accept edge (latency 1); undefined, it runs full WIDTH iterations; result values per REQ-020 identical in both builds.

Verification
REQ-029 SHALL cover add, WIDTH=64: A=FFFF_FFFF_FFFF_FFFF, B=1 -> after 1 cycle Y=0, ZERO=1, COUT=1, OVF=0; A=7FFF_FFFF_FFFF_FFFF, B=1 -> Y=8000_0000_0000_0000, OVF=1.
REQ-030 SHALL cover mul: A=FFFF_FFFF_FFFF_FFFF, B=2 -> out_valid exactly 64 cycles after accept, Y=FFFF_FFFF_FFFF_FFFE, Y_hi=1.
REQ-031 SHALL cover div: A=100, B=7 -> Y=14, REM=2, DIV0=0 after 64 cycles; A=5, B=0 -> Y=all-ones, REM=5, DIV0=1 at latency 64 (macro off) or 1 (macro on).
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles after sub A=3, B=5 -> Y=FFFF_FFFF_FFFF_FFFE, COUT=0 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover reset mid-mul: rst_n=0 at BUSY cycle 30 -> out_valid=0, in_ready=1 after release, following add 2+3 returns Y=5.
REQ-034 SHALL cover WIDTH=8 build: mul A=FF, B=FF -> Y=01, Y_hi=FE after 8 cycles.
